// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the sequential CLA adder.
// State encoding, nibble width and index sizing.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBW = 4;

    // Index width for a nibble counter; at least one bit even for NIB=1.
    function automatic int idx_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// 4-bit carry-lookahead adder cell.
// Pure combinational; shared by the sequential controller.
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract: one nibble per cycle through a shared
// 4-bit CLA cell, with valid/ready on both request and result sides.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / NIBW;
    localparam int IW  = idx_w(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [NIBW-1:0]  a_nib;
    logic [NIBW-1:0]  b_nib;
    logic [NIBW-1:0]  s_nib;
    logic             c_out;
    logic             c3;

    CLA_4bit u_cell (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (s_nib),
        .cout (c_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake; a new request may overlap result pickup.
    always_comb begin
        state_n  = state;
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        accept   = in_valid && in_ready;
        last     = (idx == LAST);
        unique case (state)
            IDLE: if (accept) state_n = RUN;
            RUN:  if (last) state_n = DONE;
            DONE: begin
                if (out_ready) begin
                    state_n = accept ? RUN : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign out_valid = (state == DONE);

    // Nibble mux into the cell and demux of its sum into the work register.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        acc_n = acc;
        for (int k = 0; k < NIB; k++) begin
            if (idx == IW'(k)) begin
                a_nib = a_r[k*NIBW +: NIBW];
                b_nib = b_r[k*NIBW +: NIBW];
                acc_n[k*NIBW +: NIBW] = s_nib;
            end
        end
        c3 = a_nib[NIBW-1] ^ b_nib[NIBW-1] ^ s_nib[NIBW-1];
    end

    // Operand latch, nibble stepping and result capture on the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_n;
            carry <= c_out;
            idx   <= idx + IW'(1);
            if (last) begin
                sum  <= acc_n;
                cout <= c_out;
                ovf  <= c3 ^ c_out;
            end
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16 and WIDTH=4 builds).
// Directed table, random vectors against an arithmetic model, corner sequences.
module tb_cla_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, sub4, cout4, ovf4;

    int total = 0;
    int bad   = 0;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_seq_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Model: true integer sum, signed overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci, input logic s);
        logic [15:0] ye;
        logic [16:0] full;
        logic        v;
        ye   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, ye} + {16'd0, (s ? 1'b1 : ci)};
        v    = (x[15] == ye[15]) && (full[15] != x[15]);
        return {v, full[16], full[15:0]};
    endfunction

    // Issue one request, wait for the result, leave it pending on out_valid.
    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic s, output int lat,
                         output logic ir_seen);
        @(negedge clk);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        lat = 0;
        ir_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    int          lat;
    logic        ir_seen;
    logic [17:0] e;
    logic [15:0] ra, rb;
    logic        rc, rs;

    initial begin
        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat, ir_seen);
            chk($sformatf("lat%0d", i), lat, 4);
            chk($sformatf("ir_run%0d", i), ir_seen, 0);
            chk($sformatf("sum%0d", i), sum, tbl[i].s);
            chk($sformatf("cout%0d", i), cout, tbl[i].co);
            chk($sformatf("ovf%0d", i), ovf, tbl[i].ov);
            release_out();
        end

        for (int i = 0; i < 25; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom; rs = $urandom;
            e = model(ra, rb, rc, rs);
            issue(ra, rb, rc, rs, lat, ir_seen);
            chk("rnd_lat", lat, 4);
            chk("rnd_sum", sum, e[15:0]);
            chk("rnd_cout", cout, e[16]);
            chk("rnd_ovf", ovf, e[17]);
            release_out();
        end

        // Backpressure then back-to-back accept on the same edge.
        e = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, ir_seen);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", sum, e[15:0]);
            chk("bp_cout", cout, e[16]);
            chk("bp_ovf", ovf, e[17]);
        end
        @(negedge clk);
        chk("bp_in_ready_lo", in_ready, 0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'h0005; b = 16'h0007; cin = 1'b0; sub = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_valid_drop", out_valid, 0);
        lat = 0;
        ir_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_lat", lat, 4);
        chk("b2b_ir_run", ir_seen, 0);
        chk("b2b_sum", sum, 16'hFFFE);
        chk("b2b_cout", cout, 0);
        release_out();

        // Reset after two nibbles aborts the operation.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_sum", sum, 0);
        chk("rst_mid_cout", cout, 0);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ignored_valid", out_valid, 0);
        chk("rst_ignored_in_ready", in_ready, 1);
        e = model(16'hABCD, 16'h1234, 1'b1, 1'b0);
        issue(16'hABCD, 16'h1234, 1'b1, 1'b0, lat, ir_seen);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_sum", sum, e[15:0]);
        chk("post_rst_cout", cout, e[16]);
        release_out();

        // WIDTH=4 build: single RUN cycle.
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; sub4 = 1'b0; in_valid4 = 1'b1;
        chk("w4_in_ready", in_ready4, 1);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        chk("w4_valid_early", out_valid4, 0);
        @(posedge clk);
        #1;
        chk("w4_valid", out_valid4, 1);
        chk("w4_sum", sum4, 4'h1);
        chk("w4_cout", cout4, 1);
        chk("w4_ovf", ovf4, 1);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        chk("w4_drop", out_valid4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
